ms_latch_buf: RTL and testbench
===============================

Name: ms_latch_buf

Overview:
- Parametrised successor to the 8-bit gated capture latch.
- Captures WIDTH-bit words on a gate strobe into a DEPTH-entry synchronous buffer and presents them in order with a valid/read handshake.
- Optional flow-through path gives zero-latency transparency when the buffer is empty.
- Sits between bus-side producers and slower span/memory consumers, replacing banks of ad-hoc gated latches.

Parameters:
- WIDTH, 8, data word width in bits (>=1)
- DEPTH, 4, number of buffer entries (power of 2, >=2)
- CW, $clog2(DEPTH+1), width of the count output (derived; do not override)

Ports:
- clk  input  1  sole clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- g  input  1  capture strobe; d_in is written on the rising edge where g=1
- d_in  input  WIDTH  data to capture
- flow_thru  input  1  enables the zero-latency bypass when empty
- out_rd  input  1  consumer read strobe; pops the head when out_valid=1
- d_out  output  WIDTH  head-of-buffer data (or bypassed d_in)
- out_valid  output  1  d_out holds a valid word
- full  output  1  count==DEPTH
- empty  output  1  count==0
- count  output  CW  number of stored entries, 0..DEPTH
- overflow  output  1  sticky: a capture was dropped

Behaviour:
- Reset: reset=1 at a rising edge clears wr_ptr, rd_ptr, count and overflow.
  - Storage array is not cleared.
  - The hold register, when present, is cleared to 0.
  - Reset has priority over g and out_rd in the same cycle; an in-flight word is discarded.
- Outputs after reset: count=0, empty=1, full=0, overflow=0, out_valid=0 (unless bypass is active), d_out=0.
- Write: g=1 and (not full, or out_rd=1 with out_valid=1 from storage) writes d_in into mem[wr_ptr]; wr_ptr increments modulo DEPTH.
- Read: out_rd=1 and out_valid=1 from storage pops mem[rd_ptr]; rd_ptr increments modulo DEPTH.
  - out_rd=1 with out_valid=0 is ignored; no pointer change.
- Count: +1 on write only, -1 on read only, unchanged on simultaneous write and read.
- Latency:
  - Captured word appears on d_out one cycle after the capture edge if it is the new head.
  - d_out is combinational from mem[rd_ptr].
- Full with g=1 and out_rd=0: word dropped; overflow set on that edge and held until reset.
- Full with g=1 and out_rd=1: pop and push both occur; count stays DEPTH; no overflow.
- Empty without bypass: out_valid=0, d_out=0 (see optional feature).
- Bypass, active when flow_thru=1 and empty=1:
  - out_valid=g and d_out=d_in, both combinational.
  - If out_rd=1 in that cycle, the word is consumed and not written; count stays 0.
  - If out_rd=0, the word is written to storage normally and bypass ends next cycle.
- flow_thru has no effect when count>0, so ordering is preserved.
- Pointers wrap DEPTH-1 -> 0 with no bubble.
- full and empty are decoded from count, never from pointer equality alone.

Optional Feature:
- Macro: MS_LATCH_BUF_HOLD_EN.
- Defined:
  - Adds a WIDTH-bit hold register loaded with d_out on every successful pop (bypass pops included).
  - When empty and not bypassing, d_out shows the hold register (last value read) and out_valid=0, giving latch-like hold semantics.
  - Hold register resets to 0.
- Undefined: no hold register; d_out=0 whenever empty and not bypassing.

Test Plan:
- Reset then idle 3 cycles -> count=0, empty=1, full=0, overflow=0, out_valid=0, d_out=0.
- flow_thru=0; g with d_in=0x11,0x22,0x33 on consecutive cycles; then out_rd x3 -> d_out 0x11,0x22,0x33 in order; count 3->0; empty=1 after the third pop.
- DEPTH=4: write 0xA0..0xA4 with no reads -> count=4, full=1, overflow=1, 0xA4 lost. Then g=1 d_in=0xB0 with out_rd=1 -> popped 0xA0, count stays 4, overflow stays 1.
- Wrap: 10 write/read pairs of 0x01..0x0A with interleaved single-entry occupancy -> output sequence 0x01..0x0A exactly, no overflow, pointers wrap twice.
- flow_thru=1, empty, g=1 d_in=0x5A, out_rd=1 -> same cycle out_valid=1, d_out=0x5A, count stays 0. Repeat with out_rd=0 -> count=1 next cycle, d_out=0x5A.
- Reset asserted with count=3 and g=out_rd=1 -> next cycle count=0, overflow=0, out_valid=0. With MS_LATCH_BUF_HOLD_EN, a 0xC3 pop then empty shows d_out=0xC3, out_valid=0.

Source files
------------

// File: rtl/ms_latch_buf.sv
// rtl/ms_latch_buf.sv - gated capture buffer: DEPTH-entry in-order store with optional flow-through bypass
// Optional hold register on the read side is enabled by defining MS_LATCH_BUF_HOLD_EN.
module ms_latch_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             g,
  input  logic [WIDTH-1:0] d_in,
  input  logic             flow_thru,
  input  logic             out_rd,
  output logic [WIDTH-1:0] d_out,
  output logic             out_valid,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             overflow_q;

  logic             stor_valid;
  logic             bypass;
  logic             bypass_pop;
  logic             pop_stor;
  logic             push;
  logic             drop;
  logic [WIDTH-1:0] idle_data;

  assign empty      = (count_q == '0);
  assign full       = (count_q == CW'(DEPTH));
  assign count      = count_q;
  assign overflow   = overflow_q;

  assign stor_valid = !empty;
  assign bypass     = flow_thru && empty;
  assign bypass_pop = bypass && g && out_rd;
  assign pop_stor   = out_rd && stor_valid;

  // A full buffer still accepts a capture when the head is leaving in the same cycle.
  assign push = g && (!full || pop_stor) && !bypass_pop;
  assign drop = g && full && !pop_stor;

`ifdef MS_LATCH_BUF_HOLD_EN
  logic [WIDTH-1:0] hold_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= '0;
    end else if (pop_stor || bypass_pop) begin
      hold_q <= d_out;
    end
  end

  assign idle_data = hold_q;
`else
  assign idle_data = '0;
`endif

  always_comb begin
    out_valid = 1'b0;
    d_out     = idle_data;
    if (stor_valid) begin
      out_valid = 1'b1;
      d_out     = mem[rd_ptr];
    end else if (bypass) begin
      out_valid = g;
      d_out     = d_in;
    end
  end

  // Storage is deliberately left uninitialised; count gates every read of it.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[wr_ptr] <= d_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_stor) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop_stor})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ms_latch_buf.sv
// tb/tb_ms_latch_buf.sv - directed self-checking bench for ms_latch_buf (DEPTH=4, WIDTH=8)
module tb_ms_latch_buf;

`ifdef MS_LATCH_BUF_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       g;
  logic [7:0] d_in;
  logic       flow_thru;
  logic       out_rd;
  logic [7:0] d_out;
  logic       out_valid;
  logic       full;
  logic       empty;
  logic [2:0] count;
  logic       overflow;

  int vec  = 0;
  int errs = 0;

  ms_latch_buf #(.WIDTH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .g         (g),
    .d_in      (d_in),
    .flow_thru (flow_thru),
    .out_rd    (out_rd),
    .d_out     (d_out),
    .out_valid (out_valid),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle so checks sample mid-cycle.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1; g = 1'b0; d_in = 8'h00; flow_thru = 1'b0; out_rd = 1'b0;
    step(); step();
    reset = 1'b0;
    step(); step(); step();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_dout", d_out, 8'h00);

    // In-order capture and drain
    g = 1'b1; d_in = 8'h11; step();
    chk("wr1_dout", d_out, 8'h11);
    chk("wr1_count", count, 1);
    d_in = 8'h22; step();
    d_in = 8'h33; step();
    g = 1'b0; #1;
    chk("wr3_count", count, 3);
    chk("wr3_head", d_out, 8'h11);
    out_rd = 1'b1; step();
    chk("rd1_dout", d_out, 8'h22);
    chk("rd1_count", count, 2);
    step();
    chk("rd2_dout", d_out, 8'h33);
    chk("rd2_count", count, 1);
    step();
    out_rd = 1'b0; #1;
    chk("rd3_count", count, 0);
    chk("rd3_empty", empty, 1);
    chk("rd3_valid", out_valid, 0);
    chk("rd3_dout", d_out, HOLD ? 8'h33 : 8'h00);

    // Read while empty is ignored
    out_rd = 1'b1; step();
    out_rd = 1'b0; #1;
    chk("rd_empty_count", count, 0);

    // Overfill: 0xA4 dropped
    g = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d_in = 8'hA0 + 8'(i);
      step();
    end
    g = 1'b0; #1;
    chk("ovf_count", count, 4);
    chk("ovf_full", full, 1);
    chk("ovf_flag", overflow, 1);
    chk("ovf_head", d_out, 8'hA0);
    g = 1'b1; d_in = 8'hB0; out_rd = 1'b1; #1;
    chk("full_rw_pop", d_out, 8'hA0);
    step();
    g = 1'b0; out_rd = 1'b0; #1;
    chk("full_rw_count", count, 4);
    chk("full_rw_ovf", overflow, 1);
    chk("full_rw_head", d_out, 8'hA1);
    out_rd = 1'b1; step();
    chk("drain_a2", d_out, 8'hA2);
    step();
    chk("drain_a3", d_out, 8'hA3);
    step();
    chk("drain_b0", d_out, 8'hB0);
    chk("drain_b0_cnt", count, 1);
    step();
    out_rd = 1'b0; #1;
    chk("drain_empty", empty, 1);
    chk("drain_ovf_sticky", overflow, 1);
    reset = 1'b1; step();
    reset = 1'b0; #1;
    chk("ovf_cleared", overflow, 0);

    // Single-entry occupancy across two pointer wraps
    for (int i = 1; i <= 10; i++) begin
      g = 1'b1; out_rd = 1'b0; d_in = 8'(i); step();
      g = 1'b0; out_rd = 1'b1; #1;
      chk("wrap_valid", out_valid, 1);
      chk("wrap_dout", d_out, 32'(i));
      step();
    end
    out_rd = 1'b0; #1;
    chk("wrap_count", count, 0);
    chk("wrap_ovf", overflow, 0);

    // Flow-through bypass
    flow_thru = 1'b1; g = 1'b1; d_in = 8'h5A; out_rd = 1'b1; #1;
    chk("byp_valid", out_valid, 1);
    chk("byp_dout", d_out, 8'h5A);
    step();
    g = 1'b0; out_rd = 1'b0; #1;
    chk("byp_count", count, 0);
    chk("byp_idle_valid", out_valid, 0);
    g = 1'b1; d_in = 8'h5A; step();
    g = 1'b0; d_in = 8'h77; #1;
    chk("byp_wr_count", count, 1);
    chk("byp_wr_dout", d_out, 8'h5A);
    chk("byp_wr_valid", out_valid, 1);
    out_rd = 1'b1; step();
    out_rd = 1'b0; flow_thru = 1'b0; #1;
    chk("byp_drain", count, 0);
    chk("byp_idle_dout", d_out, HOLD ? 8'h5A : 8'h00);

    // Reset beats a simultaneous capture and read
    g = 1'b1;
    d_in = 8'hC0; step();
    d_in = 8'hC1; step();
    d_in = 8'hC2; step();
    g = 1'b0; #1;
    chk("pre_rst_count", count, 3);
    reset = 1'b1; g = 1'b1; out_rd = 1'b1; d_in = 8'hEE; step();
    reset = 1'b0; g = 1'b0; out_rd = 1'b0; #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_dout", d_out, 8'h00);

    // Last popped value seen while idle (hold feature) or zero
    g = 1'b1; d_in = 8'hC3; step();
    g = 1'b0; out_rd = 1'b1; #1;
    chk("c3_head", d_out, 8'hC3);
    step();
    out_rd = 1'b0; #1;
    chk("c3_idle_valid", out_valid, 0);
    chk("c3_idle_dout", d_out, HOLD ? 8'hC3 : 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
